// File: rtl/scope_chk_pkg.sv
// Shared types and helpers for the scope value checker.
// State encoding, beat-counter sizing and saturating increment.
package scope_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int beat_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/scope_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear and enable.
// Sticks at all-ones instead of wrapping.
module scope_chk_sat_cnt
    import scope_chk_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/scope_value_checker.sv
// Compares NUM_SAMPLES accepted words against EXPECTED and reports pass/fail.
// Define SCOPE_CHK_CAPTURE_EN to add the first_bad capture port.
module scope_value_checker
    import scope_chk_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] EXPECTED    = WIDTH'(11),
    parameter int               NUM_SAMPLES = 8,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
`ifdef SCOPE_CHK_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] first_bad
`endif
);

    localparam int BEAT_W = beat_w(NUM_SAMPLES);
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(NUM_SAMPLES - 1);

    if (NUM_SAMPLES < 1) begin : g_bad_ns
        $error("NUM_SAMPLES must be >= 1");
    end

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic accept;
    logic hit;
    logic clr;

    assign accept = in_valid && in_ready_q;
    assign hit    = (in_data == EXPECTED);
    assign clr    = start && (state_q != RUN);

    scope_chk_sat_cnt #(.CNT_W(CNT_W)) u_match (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (accept && hit),
        .cnt   (match_cnt)
    );

    scope_chk_sat_cnt #(.CNT_W(CNT_W)) u_mismatch (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (accept && !hit),
        .cnt   (mismatch_cnt)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        in_ready_d = in_ready_q;
        done_d     = done_q;
        pass_d     = pass_q;
        beat_d     = beat_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    beat_d     = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
                // Final beat's own verdict is folded in, counter lags a cycle.
                if (accept && beat_q == LAST) begin
                    state_d    = DONE;
                    busy_d     = 1'b0;
                    in_ready_d = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = (mismatch_cnt == '0) && hit;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            beat_q     <= beat_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;

`ifdef SCOPE_CHK_CAPTURE_EN
    logic [WIDTH-1:0] first_bad_q, first_bad_d;

    always_comb begin
        first_bad_d = first_bad_q;
        if (clr) begin
            first_bad_d = '0;
        end else if (accept && !hit && mismatch_cnt == '0) begin
            first_bad_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_bad_q <= '0;
        end else begin
            first_bad_q <= first_bad_d;
        end
    end

    assign first_bad = first_bad_q;
`else
    // No capture register in this build.
`endif

endmodule

// File: tb/tb_scope_value_checker.sv
// Scoreboard bench for scope_value_checker, two parameterisations.
// Checks counts every cycle and the final verdict on each done rise.
module tb_scope_value_checker;

    typedef struct packed {
        logic [7:0]  m;
        logic [7:0]  mm;
        logic        p;
        logic [31:0] fb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st [2];
    logic        iv [2];
    logic [31:0] id [2];

    logic        ir0, ir1, bz0, bz1, dn0, dn1, ps0, ps1;
    logic [7:0]  mc0, mm0;
    logic [1:0]  mc1, mm1;
    logic [31:0] fb0, fb1;

    logic [1:0]  ir, bz, dn, ps;
    logic [7:0]  mc [2];
    logic [7:0]  mm [2];
    logic [31:0] fb [2];

    assign ir = {ir1, ir0};
    assign bz = {bz1, bz0};
    assign dn = {dn1, dn0};
    assign ps = {ps1, ps0};
    assign mc[0] = mc0;
    assign mm[0] = mm0;
    assign mc[1] = {6'd0, mc1};
    assign mm[1] = {6'd0, mm1};
    assign fb[0] = fb0;
    assign fb[1] = fb1;

    int checks = 0;
    int failures = 0;

    logic [31:0] acc [2][$];
    exp_t        sbq [2][$];
    logic        acc_edge [2];
    logic        dn_prev [2];

    scope_value_checker #(
        .WIDTH(32), .EXPECTED(32'd11), .NUM_SAMPLES(4), .CNT_W(8)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]),
        .in_valid(iv[0]), .in_ready(ir0), .in_data(id[0]),
        .busy(bz0), .done(dn0), .pass(ps0),
        .match_cnt(mc0), .mismatch_cnt(mm0)
`ifdef SCOPE_CHK_CAPTURE_EN
        , .first_bad(fb0)
`endif
    );

    scope_value_checker #(
        .WIDTH(32), .EXPECTED(32'd11), .NUM_SAMPLES(6), .CNT_W(2)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]),
        .in_valid(iv[1]), .in_ready(ir1), .in_data(id[1]),
        .busy(bz1), .done(dn1), .pass(ps1),
        .match_cnt(mc1), .mismatch_cnt(mm1)
`ifdef SCOPE_CHK_CAPTURE_EN
        , .first_bad(fb1)
`endif
    );

`ifndef SCOPE_CHK_CAPTURE_EN
    assign fb0 = '0;
    assign fb1 = '0;
`endif

    function automatic int ns(input int i);
        return (i == 0) ? 4 : 6;
    endfunction

    function automatic int maxc(input int i);
        return (i == 0) ? 255 : 3;
    endfunction

    task automatic chk(input string name, input int idx,
                       input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    // Accepted-beat log, rebuilt per run from the observed handshake.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            acc_edge[i] = 1'b0;
            if (!rst_n) begin
                acc[i].delete();
            end else if (st[i] && !bz[i]) begin
                acc[i].delete();
            end else if (iv[i] && ir[i]) begin
                acc[i].push_back(id[i]);
                acc_edge[i] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int m, x;
            exp_t e;
            m = 0;
            x = 0;
            for (int k = 0; k < acc[i].size(); k++) begin
                if (acc[i][k] == 32'd11) m++;
                else x++;
            end
            if (m > maxc(i)) m = maxc(i);
            if (x > maxc(i)) x = maxc(i);
            chk("match_cnt", i, mc[i], m);
            chk("mismatch_cnt", i, mm[i], x);
            if (dn[i] && !dn_prev[i]) begin
                chk("done_latency", i, acc_edge[i], 1);
                chk("beats", i, acc[i].size(), ns(i));
                chk("ready_in_done", i, ir[i], 0);
                chk("busy_in_done", i, bz[i], 0);
                if (sbq[i].size() == 0) begin
                    chk("sb_empty", i, 0, 1);
                end else begin
                    e = sbq[i].pop_front();
                    chk("pass", i, ps[i], e.p);
                    chk("final_match", i, mc[i], e.m);
                    chk("final_mismatch", i, mm[i], e.mm);
`ifdef SCOPE_CHK_CAPTURE_EN
                    chk("first_bad", i, fb[i], e.fb);
`endif
                end
            end
            dn_prev[i] = dn[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int i);
        chk("rst_ready", i, ir[i], 0);
        chk("rst_busy", i, bz[i], 0);
        chk("rst_done", i, dn[i], 0);
        chk("rst_pass", i, ps[i], 0);
        chk("rst_match", i, mc[i], 0);
        chk("rst_mismatch", i, mm[i], 0);
        chk("rst_first_bad", i, fb[i], 0);
    endtask

    task automatic pulse_start(input int i);
        st[i] = 1'b1;
        tick();
        st[i] = 1'b0;
        chk("start_done", i, dn[i], 0);
        chk("start_ready", i, ir[i], 1);
        chk("start_busy", i, bz[i], 1);
        chk("start_match", i, mc[i], 0);
        chk("start_mismatch", i, mm[i], 0);
    endtask

    task automatic send_beat(input int i, input logic [31:0] w,
                             input int gap);
        bit ok;
        iv[i] = 1'b0;
        id[i] = '0;
        repeat (gap) tick();
        iv[i] = 1'b1;
        id[i] = w;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (ir[i]) ok = 1'b1;
            tick();
        end
        if (!ok) chk("accept_timeout", i, 0, 1);
        iv[i] = 1'b0;
        id[i] = '0;
    endtask

    task automatic run(input int i, input logic [31:0] w [8],
                       input int gap);
        exp_t e;
        int m, x;
        m = 0;
        x = 0;
        e.fb = '0;
        for (int k = 0; k < ns(i); k++) begin
            if (w[k] == 32'd11) begin
                m++;
            end else begin
                if (x == 0) e.fb = w[k];
                x++;
            end
        end
        e.p  = (x == 0);
        e.m  = 8'((m > maxc(i)) ? maxc(i) : m);
        e.mm = 8'((x > maxc(i)) ? maxc(i) : x);
        sbq[i].push_back(e);
        pulse_start(i);
        for (int k = 0; k < ns(i); k++) begin
            send_beat(i, w[k], (k > 0) ? gap : 0);
        end
        repeat (2) tick();
    endtask

    logic [31:0] w [8];

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0;
            iv[i] = 1'b0;
            id[i] = '0;
            dn_prev[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) tick();
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        tick();

        w = '{11, 11, 11, 11, 0, 0, 0, 0};
        run(0, w, 0);
        w = '{11, 7, 11, 11, 0, 0, 0, 0};
        run(0, w, 0);
        w = '{11, 11, 11, 11, 0, 0, 0, 0};
        run(0, w, 3);
        w = '{3, 11, 9, 11, 0, 0, 0, 0};
        run(0, w, 3);
        w = '{5, 5, 5, 5, 5, 5, 0, 0};
        run(1, w, 0);
        w = '{11, 11, 11, 11, 11, 11, 0, 0};
        run(1, w, 1);

        pulse_start(0);
        send_beat(0, 32'd11, 0);
        send_beat(0, 32'd7, 0);
        rst_n = 1'b0;
        tick();
        check_zero(0);
        rst_n = 1'b1;
        iv[0] = 1'b1;
        id[0] = 32'd11;
        repeat (3) begin
            tick();
            chk("post_rst_ready", 0, ir[0], 0);
        end
        iv[0] = 1'b0;
        id[0] = '0;
        tick();

        for (int r = 0; r < 24; r++) begin
            int i;
            i = int'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) begin
                w[k] = ($urandom_range(0, 3) == 0) ? $urandom : 32'd11;
            end
            run(i, w, int'($urandom_range(0, 2)));
        end

        repeat (5) tick();
        chk("sb_drain", 0, sbq[0].size(), 0);
        chk("sb_drain", 1, sbq[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
